// File: rtl/stream_sink.sv
// stream_sink: receiving end of the valid/ready/last byte stream.
// Applies a periodic back-pressure pattern on s_ready, checks each accepted
// beat for incrementing data, packet length and hold stability, and keeps
// saturating statistics counters plus sticky error flags.
//
// Handshake: a beat transfers on every rising clk edge where s_valid and
// s_ready are both 1. Once s_valid is raised, the source must hold s_valid,
// s_data and s_last unchanged until that transfer; s_ready never depends
// combinationally on s_valid.
module stream_sink #(
  parameter int DATA_W       = 8,
  parameter int PKT_LEN      = 4,
  parameter int READY_PERIOD = 5,
  parameter int READY_HIGH   = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              ready_en,
  input  logic              err_clr,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  bad_pkt_count,
  output logic              err_seq,
  output logic              err_len,
  output logic              err_proto,
  output logic [1:0]        dbg_state
);

  localparam int RCNT_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam int IDX_W  = $clog2(PKT_LEN + 1);

  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(READY_PERIOD - 1);
  localparam logic [RCNT_W:0]   RCNT_HIGH = (RCNT_W + 1)'(READY_HIGH);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(PKT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
  logic                pkt_bad_q, pkt_bad_d;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [DATA_W-1:0]   exp_data_q;
  logic                prev_stall_q;
  logic [DATA_W-1:0]   prev_data_q;
  logic                prev_last_q;
  logic                pkt_done_q;
  logic [CNT_W-1:0]    beat_cnt_q, pkt_cnt_q, bad_cnt_q;
  logic                err_seq_q, err_len_q, err_proto_q;

  logic acc, seq_err, proto_hit, len_err, complete, pkt_is_bad, bad_any;

  // Ready comes only from registered pattern state and the enable pin.
  always_comb begin
    s_ready   = ready_en && ({1'b0, rcnt_q} < RCNT_HIGH);
    acc       = s_valid && s_ready;
    seq_err   = acc && (s_data != exp_data_q);
    proto_hit = prev_stall_q &&
                (!s_valid || (s_data != prev_data_q) || (s_last != prev_last_q));
  end

  // Packet framing: next state, beat index and per-packet bad marker.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    pkt_bad_d  = pkt_bad_q;
    len_err    = 1'b0;
    complete   = 1'b0;
    pkt_is_bad = 1'b0;
    bad_any    = 1'b0;
    if (acc) begin
      case (state_q)
        IDLE: begin
          if (s_last) begin
            complete = 1'b1;
            len_err  = (PKT_LEN != 1);
          end else if (PKT_LEN == 1) begin
            // Single-beat packets: a first beat without last is already long.
            len_err    = 1'b1;
            state_d    = DRAIN;
            beat_idx_d = IDX_FULL;
          end else begin
            state_d    = RECV;
            beat_idx_d = IDX_W'(1);
          end
        end
        RECV: begin
          if (s_last) begin
            complete = 1'b1;
            len_err  = (beat_idx_q != IDX_LAST);
          end else if (beat_idx_q == IDX_LAST) begin
            len_err    = 1'b1;
            state_d    = DRAIN;
            beat_idx_d = IDX_FULL;
          end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          // Excess beats are swallowed; index stays saturated.
          complete = s_last;
        end
        default: state_d = IDLE;
      endcase
      bad_any = pkt_bad_q || seq_err || len_err;
      if (complete) begin
        state_d    = IDLE;
        beat_idx_d = '0;
        pkt_bad_d  = 1'b0;
        pkt_is_bad = bad_any;
      end else begin
        pkt_bad_d  = bad_any;
      end
    end
  end

  // All registered state: FSM, pattern counter, checkers, counters, flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_idx_q   <= '0;
      pkt_bad_q    <= 1'b0;
      rcnt_q       <= '0;
      exp_data_q   <= '0;
      prev_stall_q <= 1'b0;
      prev_data_q  <= '0;
      prev_last_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      beat_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      err_seq_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      pkt_bad_q  <= pkt_bad_d;
      rcnt_q     <= (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + RCNT_W'(1);

      if (acc) begin
        // Resync to the received value so one bad beat flags only once.
        exp_data_q <= s_data + DATA_W'(1);
      end

      prev_stall_q <= s_valid && !s_ready;
      prev_data_q  <= s_data;
      prev_last_q  <= s_last;

      pkt_done_q <= complete;

      if (acc && (beat_cnt_q != CNT_MAX)) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (complete && (pkt_cnt_q != CNT_MAX)) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (pkt_is_bad && (bad_cnt_q != CNT_MAX)) bad_cnt_q <= bad_cnt_q + CNT_W'(1);

      err_seq_q   <= err_clr ? 1'b0 : (err_seq_q || seq_err);
      err_len_q   <= err_clr ? 1'b0 : (err_len_q || len_err);
      err_proto_q <= err_clr ? 1'b0 : (err_proto_q || proto_hit);
    end
  end

  assign pkt_done      = pkt_done_q;
  assign beat_count    = beat_cnt_q;
  assign pkt_count     = pkt_cnt_q;
  assign bad_pkt_count = bad_cnt_q;
  assign err_seq       = err_seq_q;
  assign err_len       = err_len_q;
  assign err_proto     = err_proto_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stream_sink.sv
// Bench for stream_sink: directed scenarios plus a randomized packet run,
// checked against a packet-level reference model.
module tb_stream_sink;

  localparam int DATA_W       = 8;
  localparam int PKT_LEN      = 4;
  localparam int READY_PERIOD = 5;
  localparam int READY_HIGH   = 3;
  localparam int CNT_W        = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              ready_en = 1'b1;
  logic              err_clr = 1'b0;
  logic              pkt_done;
  logic [CNT_W-1:0]  beat_count, pkt_count, bad_pkt_count;
  logic              err_seq, err_len, err_proto;
  logic [1:0]        dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  stream_sink #(
    .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .READY_PERIOD(READY_PERIOD),
    .READY_HIGH(READY_HIGH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ready_en(ready_en), .err_clr(err_clr), .pkt_done(pkt_done),
    .beat_count(beat_count), .pkt_count(pkt_count), .bad_pkt_count(bad_pkt_count),
    .err_seq(err_seq), .err_len(err_len), .err_proto(err_proto),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  // Works on whole packets: count beats, compare against running expected
  // data, judge length when the packet ends or overruns.
  logic [CNT_W-1:0]  exp_q[$];   // expected pkt_count at each pkt_done pulse
  int                m_cyc;
  logic [DATA_W-1:0] m_exp;
  int                m_len;
  bit                m_pkt_bad;
  int                m_beats, m_pkts, m_bad_pkts;
  bit                m_err_seq, m_err_len, m_err_proto;
  bit                m_stall;
  logic [DATA_W-1:0] m_hold_data;
  logic              m_hold_last;

  always @(posedge clk) begin
    bit rdy, set_seq, set_len, set_proto;
    if (!rst_n) begin
      m_cyc = 0; m_exp = '0; m_len = 0; m_pkt_bad = 0;
      m_beats = 0; m_pkts = 0; m_bad_pkts = 0;
      m_err_seq = 0; m_err_len = 0; m_err_proto = 0;
      m_stall = 0; m_hold_data = '0; m_hold_last = 1'b0;
      exp_q.delete();
    end else begin
      rdy = ready_en && ((m_cyc % READY_PERIOD) < READY_HIGH);
      set_seq = 0; set_len = 0;
      set_proto = m_stall && (!s_valid || s_data != m_hold_data || s_last != m_hold_last);
      if (s_valid && rdy) begin
        if (m_beats < 2**CNT_W - 1) m_beats++;
        if (s_data != m_exp) set_seq = 1;
        m_exp = s_data + 1'b1;
        m_len++;
        if (s_last && m_len != PKT_LEN) set_len = 1;
        if (!s_last && m_len == PKT_LEN) set_len = 1;
        if (set_seq || set_len) m_pkt_bad = 1;
        if (s_last) begin
          if (m_pkts < 2**CNT_W - 1) m_pkts++;
          if (m_pkt_bad && m_bad_pkts < 2**CNT_W - 1) m_bad_pkts++;
          exp_q.push_back(CNT_W'(m_pkts));
          m_len = 0; m_pkt_bad = 0;
        end
      end
      if (err_clr) begin
        m_err_seq = 0; m_err_len = 0; m_err_proto = 0;
      end else begin
        m_err_seq   = m_err_seq   | set_seq;
        m_err_len   = m_err_len   | set_len;
        m_err_proto = m_err_proto | set_proto;
      end
      m_stall = s_valid && !rdy;
      m_hold_data = s_data;
      m_hold_last = s_last;
      m_cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; err_clr = 1'b0; ready_en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the listed beats obeying s_ready; last on the final beat if asked.
  task automatic send_list(input logic [DATA_W-1:0] d[$], input bit with_last,
                           input int max_gap);
    for (int i = 0; i < d.size(); i++) begin
      bit got;
      int waited;
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = with_last && (i == d.size() - 1);
      got = 0; waited = 0;
      while (!got && waited < 64) begin
        @(negedge clk);
        got = s_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      n_total++;
      if (!got) begin
        n_bad++;
        $display("FAIL accept_timeout: beat %0d data %0h not accepted in %0d cycles",
                 i, d[i], waited);
      end
      s_valid = 1'b0;
      if (s_last) begin
        s_last = 1'b0;
        @(negedge clk);
        n_total++;
        if (pkt_done !== 1'b1) begin
          n_bad++;
          $display("FAIL pkt_done_pulse: got %0b want 1", pkt_done);
        end
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pkt_count_sb: got %0d want <no packet expected>", pkt_count);
        end else begin
          logic [CNT_W-1:0] e;
          e = exp_q.pop_front();
          if (pkt_count !== e) begin
            n_bad++;
            $display("FAIL pkt_count_sb: got %0d want %0d", pkt_count, e);
          end
        end
        @(posedge clk);
        #1;
      end
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2 * READY_PERIOD; i++) begin
      @(negedge clk);
      n_total++;
      if (s_ready !== ((i % READY_PERIOD) < READY_HIGH)) begin
        n_bad++;
        $display("FAIL reset_ready_pattern[%0d]: got %0b want %0b", i, s_ready,
                 (i % READY_PERIOD) < READY_HIGH);
      end
      if (i == 0) begin
        n_total++;
        if ({beat_count, pkt_count, bad_pkt_count} !== '0) begin
          n_bad++;
          $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                   beat_count, pkt_count, bad_pkt_count);
        end
        n_total++;
        if ({pkt_done, err_seq, err_len, err_proto, dbg_state} !== 6'b0) begin
          n_bad++;
          $display("FAIL reset_flags: got done=%0b seq=%0b len=%0b proto=%0b st=%0d want all 0",
                   pkt_done, err_seq, err_len, err_proto, dbg_state);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_packet();
    logic [DATA_W-1:0] q[$];
    for (int i = 0; i < 4; i++) q.push_back(DATA_W'(i));
    send_list(q, 1'b1, 0);
    idle(2);
    @(negedge clk);
    n_total++;
    if (pkt_count !== CNT_W'(m_pkts) || beat_count !== CNT_W'(m_beats) || m_pkts != 1 || m_beats != 4) begin
      n_bad++;
      $display("FAIL good_counts: got pkts=%0d beats=%0d want pkts=1 beats=4 (model %0d/%0d)",
               pkt_count, beat_count, m_pkts, m_beats);
    end
    n_total++;
    if ({err_seq, err_len, err_proto} !== 3'b000 || bad_pkt_count !== '0) begin
      n_bad++;
      $display("FAIL good_no_errors: got seq=%0b len=%0b proto=%0b bad=%0d want 0",
               err_seq, err_len, err_proto, bad_pkt_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_seq_error();
    logic [DATA_W-1:0] q[$];
    do_reset();
    q.push_back(8'd0); q.push_back(8'd1); q.push_back(8'd5); q.push_back(8'd6);
    send_list(q, 1'b1, 1);
    @(negedge clk);
    n_total++;
    if (err_seq !== 1'b1 || err_seq !== m_err_seq) begin
      n_bad++;
      $display("FAIL seq_flag: got %0b want 1 (model %0b)", err_seq, m_err_seq);
    end
    n_total++;
    if (bad_pkt_count !== CNT_W'(m_bad_pkts) || m_bad_pkts != 1) begin
      n_bad++;
      $display("FAIL seq_bad_count: got %0d want 1 (model %0d)", bad_pkt_count, m_bad_pkts);
    end
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 7; i <= 10; i++) q.push_back(DATA_W'(i));
    send_list(q, 1'b1, 1);
    @(negedge clk);
    n_total++;
    if (bad_pkt_count !== CNT_W'(m_bad_pkts) || pkt_count !== CNT_W'(m_pkts) || m_bad_pkts != 1) begin
      n_bad++;
      $display("FAIL seq_resync_clean: got bad=%0d pkts=%0d want bad=1 pkts=2",
               bad_pkt_count, pkt_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_len_error();
    logic [DATA_W-1:0] q[$];
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(DATA_W'(i));
    send_list(q, 1'b1, 0);                 // short: last on third beat
    @(negedge clk);
    n_total++;
    if (err_len !== 1'b1 || err_len !== m_err_len) begin
      n_bad++;
      $display("FAIL len_short_flag: got %0b want 1", err_len);
    end
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 3; i < 3 + PKT_LEN; i++) q.push_back(DATA_W'(i));
    send_list(q, 1'b0, 0);                 // full length, no last yet
    @(negedge clk);
    n_total++;
    if (dbg_state !== 2'd2) begin
      n_bad++;
      $display("FAIL len_long_drain_state: got %0d want 2", dbg_state);
    end
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(DATA_W'(3 + PKT_LEN)); q.push_back(DATA_W'(4 + PKT_LEN));
    send_list(q, 1'b1, 0);                 // six beats total, last on 8
    @(negedge clk);
    n_total++;
    if (pkt_count !== CNT_W'(m_pkts) || bad_pkt_count !== CNT_W'(m_bad_pkts) || m_pkts != 2 || m_bad_pkts != 2) begin
      n_bad++;
      $display("FAIL len_counts: got pkts=%0d bad=%0d want 2/2", pkt_count, bad_pkt_count);
    end
    n_total++;
    if (dbg_state !== 2'd0 || err_seq !== 1'b0) begin
      n_bad++;
      $display("FAIL len_back_idle: got st=%0d seq=%0b want st=0 seq=0", dbg_state, err_seq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_protocol();
    logic [DATA_W-1:0] q[$];
    do_reset();
    ready_en = 1'b0;
    s_valid = 1'b1; s_data = 8'd4; s_last = 1'b0;
    idle(3);
    s_data = 8'd9;
    idle(1);
    ready_en = 1'b1;
    q.push_back(8'd9);
    send_list(q, 1'b0, 0);
    @(negedge clk);
    n_total++;
    if (err_proto !== 1'b1 || err_proto !== m_err_proto) begin
      n_bad++;
      $display("FAIL proto_flag: got %0b want 1", err_proto);
    end
    n_total++;
    if (beat_count !== CNT_W'(m_beats) || m_beats != 1) begin
      n_bad++;
      $display("FAIL proto_beat_kept: got %0d want 1", beat_count);
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    @(negedge clk);
    n_total++;
    if ({err_seq, err_len, err_proto} !== 3'b000) begin
      n_bad++;
      $display("FAIL clr_flags: got seq=%0b len=%0b proto=%0b want 0",
               err_seq, err_len, err_proto);
    end
    n_total++;
    if (beat_count !== CNT_W'(m_beats) || pkt_count !== CNT_W'(m_pkts)) begin
      n_bad++;
      $display("FAIL clr_counters: got beats=%0d pkts=%0d want %0d/%0d",
               beat_count, pkt_count, m_beats, m_pkts);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] q[$];
    do_reset();
    q.push_back(8'd0); q.push_back(8'd1);
    send_list(q, 1'b0, 0);
    do_reset();
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(DATA_W'(i));
    send_list(q, 1'b1, 1);
    @(negedge clk);
    n_total++;
    if (pkt_count !== 16'd1 || beat_count !== 16'd4) begin
      n_bad++;
      $display("FAIL mid_reset_counts: got pkts=%0d beats=%0d want 1/4", pkt_count, beat_count);
    end
    n_total++;
    if ({err_seq, err_len, err_proto} !== 3'b000 || bad_pkt_count !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_errors: got seq=%0b len=%0b proto=%0b bad=%0d want 0",
               err_seq, err_len, err_proto, bad_pkt_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] nxt;
    do_reset();
    nxt = '0;
    for (int p = 0; p < 20; p++) begin
      int r, len;
      r = $urandom_range(0, 7);
      len = (r == 0) ? PKT_LEN - 1 : (r == 1) ? PKT_LEN + 2 : PKT_LEN;
      q.delete();
      for (int b = 0; b < len; b++) begin
        logic [DATA_W-1:0] v;
        v = nxt;
        if ($urandom_range(0, 9) == 0) v = v + 8'd3;
        q.push_back(v);
        nxt = v + 1'b1;
      end
      send_list(q, 1'b1, 2);
      if ($urandom_range(0, 3) == 0) begin
        ready_en = 1'b0;
        idle($urandom_range(1, 3));
        ready_en = 1'b1;
      end
    end
    idle(2);
    @(negedge clk);
    n_total++;
    if (beat_count !== CNT_W'(m_beats) || pkt_count !== CNT_W'(m_pkts) ||
        bad_pkt_count !== CNT_W'(m_bad_pkts)) begin
      n_bad++;
      $display("FAIL rand_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               beat_count, pkt_count, bad_pkt_count, m_beats, m_pkts, m_bad_pkts);
    end
    n_total++;
    if ({err_seq, err_len, err_proto} !== {m_err_seq, m_err_len, m_err_proto}) begin
      n_bad++;
      $display("FAIL rand_flags: got %0b%0b%0b want %0b%0b%0b", err_seq, err_len, err_proto,
               m_err_seq, m_err_len, m_err_proto);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_sb_drain: got %0d unmatched packets want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_packet();
    test_seq_error();
    test_len_error();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
